regfile_32x32_2r1w: RTL and testbench

- 32-entry by 32-bit general-purpose register file: one write port, two independent read ports.
- Sits in the CPU datapath between instruction decode (register addresses) and the ALU operand/writeback paths.
- Writes are synchronous on a single clock, gated by a mode bit; reads are combinational.
- Synchronous active-low reset clears every entry.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_32x32_2r1w.sv | 41 ++++
 tb/tb_regfile_32x32_2r1w.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the 32x32 general-purpose register file.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_32x32_2r1w.sv
// 32x32 register file: one synchronous write port gated by mode, two combinational read ports.
// Register 0 is ordinary storage; reads show pre-edge contents during a same-address write.
module regfile_32x32_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
    parameter int unsigned DEPTH  = regfile_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    if (DEPTH != (1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] regs [DEPTH];

    // Reset wins over a simultaneous write; the write is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (mode) begin
            regs[write_addr] <= write_data;
        end
    end

    assign read_data1 = regs[read_addr1];
    assign read_data2 = regs[read_addr2];

endmodule

// File: tb/tb_regfile_32x32_2r1w.sv
// Scoreboard bench for regfile_32x32_2r1w: driver pushes expected reads, monitor pops and compares.
module tb_regfile_32x32_2r1w;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    regfile_32x32_2r1w #(
        .DATA_W(32),
        .ADDR_W(5),
        .DEPTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .write_addr(write_addr),
        .write_data(write_data),
        .read_addr1(read_addr1),
        .read_addr2(read_addr2),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp1;
        logic [31:0] exp2;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    bit          known = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // Apply one cycle of stimulus at the falling edge, record what the reads must
    // show before the next rising edge, then apply the architectural effect of that edge.
    task automatic cycle(input bit rst_n, input bit md, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra1,
                         input logic [4:0] ra2, input string tag);
        exp_t e;
        @(negedge clk);
        reset      = rst_n;
        mode       = md;
        write_addr = wa;
        write_data = wd;
        read_addr1 = ra1;
        read_addr2 = ra2;
        if (known) begin
            e.exp1 = model[ra1];
            e.exp2 = model[ra2];
            e.tag  = tag;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (!rst_n) begin
            foreach (model[i]) model[i] = 32'h0;
            known = 1'b1;
        end else if (md) begin
            model[wa] = wd;
        end
    endtask

    // Monitor: reads are combinational, so the outputs are valid shortly after each drive.
    always @(negedge clk) begin
        #2;
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (read_data1 !== e.exp1) begin
                errors++;
                $display("FAIL %s rd1 addr=%0d got=%08h exp=%08h", e.tag, read_addr1, read_data1, e.exp1);
            end
            checks++;
            if (read_data2 !== e.exp2) begin
                errors++;
                $display("FAIL %s rd2 addr=%0d got=%08h exp=%08h", e.tag, read_addr2, read_data2, e.exp2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; mode = 1'b0; write_addr = '0; write_data = '0;
        read_addr1 = '0; read_addr2 = '0;

        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "reset");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, "reset_hold");
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "reset_sweep");

        cycle(1'b1, 1'b1, 5'd0, 32'h09191232, 5'd0, 5'd1, "wr_r0");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, "rd_r0");
        cycle(1'b1, 1'b1, 5'd1, 32'h0931924B, 5'd0, 5'd1, "wr_r1");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, "rd_r0_r1");

        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 5'd2, 32'hDEADBEEF, 5'd2, 5'd2, "mode_gate");
        cycle(1'b1, 1'b1, 5'd2, 32'hDEADBEEF, 5'd2, 5'd0, "wr_r2");
        cycle(1'b1, 1'b0, 5'd2, 32'h0, 5'd2, 5'd1, "rd_r2");

        cycle(1'b1, 1'b1, 5'd5, 32'h11111111, 5'd5, 5'd5, "wr_r5_old");
        cycle(1'b1, 1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5, "rdw_before");
        cycle(1'b1, 1'b0, 5'd5, 32'h0, 5'd5, 5'd5, "rdw_after");

        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b1, 5'(i), 32'hA5A50000 + 32'(i), 5'(i), 5'((i + 31) % 32), "sweep_wr");
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i), "sweep_rd");

        cycle(1'b0, 1'b1, 5'd7, 32'hFFFFFFFF, 5'd7, 5'd0, "rst_prio_edge");
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "rst_prio_sweep");

        for (int i = 0; i < 400; i++) begin
            bit rst_n;
            rst_n = ($urandom_range(0, 39) != 0);
            cycle(rst_n, 1'($urandom), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), "random");
        end

        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "final_sweep");

        repeat (3) @(negedge clk);
        #4;
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
